pic_irr: RTL and testbench

PIC_IRR -- requirements
Module: pic_irr

---
 rtl/pic_pkg.sv | 11 +
 rtl/pic_irr_if.sv | 23 ++
 rtl/pic_irr_cell.sv | 25 ++
 rtl/pic_irr.sv | 53 +++++
 tb/tb_pic_irr.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants for the interrupt request register block
package pic_pkg;
    localparam int NUM_IR = 8;

    localparam logic [1:0] INTA_IDLE   = 2'd0;
    localparam logic [1:0] INTA_FIRST  = 2'd1;
    localparam logic [1:0] INTA_SECOND = 2'd2;

    localparam logic EDGE  = 1'b0;
    localparam logic LEVEL = 1'b1;
endpackage

// File: rtl/pic_irr_if.sv
// rtl/pic_irr_if.sv - control/request/status bundle between control logic and pic_irr
interface pic_irr_if;
    logic                       level_or_edge_flag;
    logic [1:0]                 intAcounter;
    logic [pic_pkg::NUM_IR-1:0] mask;
    logic [2:0]                 clearHighest;
    logic                       i0, i1, i2, i3, i4, i5, i6, i7;
    logic [pic_pkg::NUM_IR-1:0] IRR;
    logic                       INT;
    logic                       specialDeliveryFlag;

    modport master (
        output level_or_edge_flag, intAcounter, mask, clearHighest,
        output i0, i1, i2, i3, i4, i5, i6, i7,
        input  IRR, INT, specialDeliveryFlag
    );

    modport slave (
        input  level_or_edge_flag, intAcounter, mask, clearHighest,
        input  i0, i1, i2, i3, i4, i5, i6, i7,
        output IRR, INT, specialDeliveryFlag
    );
endinterface

// File: rtl/pic_irr_cell.sv
// rtl/pic_irr_cell.sv - one IR line: previous-sample register, edge/level set, acknowledge clear
module pic_irr_cell (
    input  logic clk,
    input  logic reset,
    input  logic levelMode,
    input  logic ir,
    input  logic clr,
    output logic irrBit
);
    logic prev;

    // Acknowledge clear beats a same-cycle set; a held level input re-sets on the next clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev   <= 1'b0;
            irrBit <= 1'b0;
        end else begin
            prev <= ir;
            if (clr)
                irrBit <= 1'b0;
            else if (ir && (levelMode || !prev))
                irrBit <= 1'b1;
        end
    end
endmodule

// File: rtl/pic_irr.sv
// rtl/pic_irr.sv - interrupt request register: eight IR cells, INT generation, spurious flag
// Build option: PIC_IRR_SPURIOUS_EN enables the specialDeliveryFlag register.
module pic_irr
    import pic_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    pic_irr_if.slave bus
);
    logic [NUM_IR-1:0] irIn;
    logic [NUM_IR-1:0] irr;
    logic              levelMode;
    logic              ackFirst;

    assign irIn      = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};
    assign levelMode = (bus.level_or_edge_flag == LEVEL);
    assign ackFirst  = (bus.intAcounter == INTA_FIRST);

    for (genvar n = 0; n < NUM_IR; n++) begin : g_cell
        pic_irr_cell u_cell (
            .clk      (clk),
            .reset    (reset),
            .levelMode(levelMode),
            .ir       (irIn[n]),
            .clr      (ackFirst && (bus.clearHighest == 3'(n))),
            .irrBit   (irr[n])
        );
    end

    assign bus.IRR = irr;
    assign bus.INT = |(irr & ~bus.mask);

`ifdef PIC_IRR_SPURIOUS_EN
    logic spurious;

    // Set when the first INTA acknowledges an empty slot; reserved phase 3 behaves as idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spurious <= 1'b0;
        end else begin
            case (bus.intAcounter)
                INTA_FIRST:  if (!irr[bus.clearHighest]) spurious <= 1'b1;
                INTA_SECOND: spurious <= spurious;
                default:     spurious <= 1'b0;
            endcase
        end
    end

    assign bus.specialDeliveryFlag = spurious;
`else
    assign bus.specialDeliveryFlag = 1'b0;
`endif
endmodule

// File: tb/tb_pic_irr.sv
// tb/tb_pic_irr.sv - directed and randomized self-checking bench for pic_irr
module tb_pic_irr;
    import pic_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pic_irr_if bus ();
    pic_irr dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef PIC_IRR_SPURIOUS_EN
    localparam bit SPUR = 1'b1;
`else
    localparam bit SPUR = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference state: pending requests, last sampled inputs, spurious indicator.
    bit pend[8];
    bit lastIn[8];
    bit spur;

    task automatic drive(input logic [7:0] v, input logic lvl, input logic [1:0] ia,
                         input logic [2:0] ch, input logic [7:0] m);
        {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = v;
        bus.level_or_edge_flag = lvl;
        bus.intAcounter = ia;
        bus.clearHighest = ch;
        bus.mask = m;
    endtask

    function automatic logic [7:0] expIrr();
        logic [7:0] r;
        for (int n = 0; n < 8; n++) r[n] = pend[n];
        return r;
    endfunction

    function automatic logic expInt();
        logic r = 1'b0;
        for (int n = 0; n < 8; n++) if (pend[n] && !bus.mask[n]) r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, "_irr"}, bus.IRR, expIrr());
        chk({tag, "_int"}, {7'd0, bus.INT}, {7'd0, expInt()});
        chk({tag, "_flag"}, {7'd0, bus.specialDeliveryFlag}, {7'd0, spur});
    endtask

    // Apply the request-register rules to the inputs about to be clocked in.
    task automatic modelStep();
        logic [7:0] v;
        int ia, ch;
        bit wasPending;
        v  = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};
        ia = int'(bus.intAcounter);
        ch = int'(bus.clearHighest);
        wasPending = pend[ch];
        for (int n = 0; n < 8; n++) begin
            if (ia == 1 && ch == n) pend[n] = 1'b0;
            else if (v[n] && (bus.level_or_edge_flag || !lastIn[n])) pend[n] = 1'b1;
            lastIn[n] = v[n];
        end
        if (SPUR) begin
            if (ia == 1 && !wasPending) spur = 1'b1;
            else if (ia == 0 || ia == 3) spur = 1'b0;
        end
    endtask

    task automatic tick(input string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic asyncReset(input string tag);
        reset = 1'b1;
        #1;
        for (int n = 0; n < 8; n++) begin
            pend[n] = 1'b0;
            lastIn[n] = 1'b0;
        end
        spur = 1'b0;
        checkAll(tag);
        reset = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < 8; n++) begin
            pend[n] = 1'b0;
            lastIn[n] = 1'b0;
        end
        spur = 1'b0;
        drive(8'h00, EDGE, INTA_IDLE, 3'd0, 8'h00);
        #1;
        checkAll("reset");
        #1;
        reset = 1'b0;

        // Single edge pulse on IR0, held after input falls.
        drive(8'h01, EDGE, INTA_IDLE, 3'd0, 8'h00);
        tick("pulse_i0");
        chk("pulse_i0_const", bus.IRR, 8'h01);
        drive(8'h00, EDGE, INTA_IDLE, 3'd0, 8'h00);
        tick("i0_fall");
        chk("i0_fall_const", bus.IRR, 8'h01);

        // IR2..IR7 rise together, then acknowledge 1,0,2..7 while inputs stay high.
        drive(8'hFC, EDGE, INTA_IDLE, 3'd0, 8'h00);
        tick("multi_rise");
        chk("multi_rise_const", bus.IRR, 8'hFD);
        drive(8'hFC, EDGE, INTA_FIRST, 3'd1, 8'h00);
        tick("ack_1");
        drive(8'hFC, EDGE, INTA_FIRST, 3'd0, 8'h00);
        tick("ack_0");
        for (int k = 2; k < 8; k++) begin
            drive(8'hFC, EDGE, INTA_FIRST, 3'(k), 8'h00);
            tick("ack_seq");
        end
        chk("ack_done_const", bus.IRR, 8'h00);
        chk("ack_done_int", {7'd0, bus.INT}, 8'h00);
        drive(8'hFC, EDGE, INTA_IDLE, 3'd0, 8'h00);
        tick("ack_idle");

        // Masked IR0: all inputs rise, then mid-sequence async reset.
        drive(8'h00, EDGE, INTA_IDLE, 3'd0, 8'h01);
        tick("mask_low");
        drive(8'hFF, EDGE, INTA_IDLE, 3'd0, 8'h01);
        tick("mask_all");
        chk("mask_all_const", bus.IRR, 8'hFF);
        drive(8'hFF, EDGE, INTA_FIRST, 3'd0, 8'h01);
        tick("mid_seq");
        drive(8'h01, EDGE, INTA_IDLE, 3'd0, 8'h01);
        asyncReset("mid_reset");
        chk("mid_reset_const", bus.IRR, 8'h00);
        tick("post_reset_edge");
        chk("masked_i0_int", {7'd0, bus.INT}, 8'h00);

        // Level mode: clear wins for one clock, then re-sets.
        drive(8'h00, LEVEL, INTA_IDLE, 3'd0, 8'h00);
        asyncReset("lvl_reset");
        drive(8'hFC, LEVEL, INTA_IDLE, 3'd0, 8'h00);
        tick("lvl_hold");
        drive(8'hFC, LEVEL, INTA_FIRST, 3'd3, 8'h00);
        tick("lvl_clr3");
        chk("lvl_clr3_const", bus.IRR, 8'hF4);
        drive(8'hFC, LEVEL, INTA_IDLE, 3'd3, 8'h00);
        tick("lvl_reset3");
        chk("lvl_reset3_const", bus.IRR, 8'hFC);

        // Spurious acknowledge of an empty slot.
        drive(8'h00, EDGE, INTA_IDLE, 3'd0, 8'h00);
        asyncReset("spur_reset");
        drive(8'h00, EDGE, INTA_FIRST, 3'd5, 8'h00);
        tick("spur_first");
        chk("spur_first_const", {7'd0, bus.specialDeliveryFlag}, {7'd0, SPUR});
        drive(8'h00, EDGE, INTA_SECOND, 3'd5, 8'h00);
        tick("spur_second");
        drive(8'h00, EDGE, INTA_IDLE, 3'd5, 8'h00);
        tick("spur_idle");
        chk("spur_idle_const", {7'd0, bus.specialDeliveryFlag}, 8'h00);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 400; it++) begin
            logic [1:0] ia;
            int r;
            r  = int'($urandom_range(0, 9));
            ia = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            drive(8'($urandom), 1'($urandom), ia, 3'($urandom), 8'($urandom));
            if ($urandom_range(0, 49) == 0)
                asyncReset("rand_reset");
            else
                tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
